ysyx_040750_csr_regfile: RTL and testbench
==========================================

Name: ysyx_040750_csr_regfile

Overview:
Architectural machine-mode CSR storage for the full-pipeline core: the write destination of CSR instructions and the source of ID-stage CSR read data.
- Committed writes arrive from WB.
- ID reads combinationally; the result feeds the CSR forwarding unit as its ID-stage value.
- Trap entry (ecall) and mret update mstatus/mepc/mcause atomically and drive the redirect targets O_mtvec and O_mepc to the fetch stage.

Parameters:
- XLEN, 64, CSR data width.
- MSTATUS_RST, 64'h0000_000a_0000_1800, mstatus reset value (UXL/SXL=2, MPP=11).
- ECALL_CAUSE, 64'd11, mcause value written on ecall (environment call from M-mode).

Ports:
- I_clk  in  1  core clock; all state updates on the rising edge.
- I_rst_n  in  1  synchronous active-low reset.
- I_csr_addr_ID  in  12  read address from ID.
- O_csr_ID  out  XLEN  read data for I_csr_addr_ID; combinational.
- O_csr_addr_err  out  1  I_csr_addr_ID is not an implemented CSR; combinational.
- I_csr_wen_WB  in  1  commit a CSR write this cycle.
- I_csr_addr_WB  in  12  write address.
- I_csr_WB  in  XLEN  write data, already computed for csrrw/s/c.
- I_ecall_WB  in  1  ecall retiring in WB.
- I_mret_WB  in  1  mret retiring in WB.
- I_pc_WB  in  XLEN  PC of the retiring instruction.
- O_mtvec  out  XLEN  current mtvec (trap target).
- O_mepc  out  XLEN  current mepc (mret target).

Behaviour:
- Implemented registers: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342.
- Reset when I_rst_n=0 at a clock edge:
  - mstatus=MSTATUS_RST.
  - mtvec, mepc and mcause all 0.
  - Reset overrides every other input in that cycle.
- Read path:
  - O_csr_ID = register selected by I_csr_addr_ID, with no internal write bypass. Same-cycle WB data reaches ID through the forwarding unit.
  - Unimplemented address: O_csr_ID=0 and O_csr_addr_err=1.
- Write path:
  - When I_csr_wen_WB=1 and the address is implemented, the register takes I_csr_WB on the next edge. Latency 1; the value is visible on O_csr_ID the following cycle.
  - A write to an unimplemented address is discarded silently.
  - mepc[1:0] and mtvec[1:0] are forced to 0 on write (direct mode, aligned).
- Trap entry (I_ecall_WB=1), single edge:
  - mepc <= {I_pc_WB[63:2],2'b0}.
  - mcause <= ECALL_CAUSE.
  - mstatus.MPIE(bit7) <= mstatus.MIE(bit3); mstatus.MIE <= 0; mstatus.MPP(bits12:11) <= 2'b11.
  - All other mstatus bits are unchanged.
- mret (I_mret_WB=1), single edge:
  - mstatus.MIE <= MPIE; MPIE <= 1; MPP <= 2'b11 (M-only core).
  - mepc and mcause are unchanged.
- Simultaneous events:
  - ecall and mret both high: ecall wins; mret is ignored.
  - Trap/mret together with a CSR write: the trap/mret update wins for every register it modifies. A write to an untouched register (e.g. mtvec) still commits.
- O_mtvec and O_mepc always reflect the registered values. A write in cycle N is visible in N+1.

Optional Feature:
Macro YSYX_040750_CSR_COUNTER_EN.
- Defined:
  - Adds mcycle (0xB00) and minstret (0xB02), 64-bit, both reset to 0.
  - mcycle increments every cycle that is not in reset.
  - Adds input I_retire_WB (1 bit); minstret increments when it is 1.
  - A CSR write to either counter has priority over its increment in that cycle (written value loaded, no +1).
  - Both counters wrap modulo 2^64.
- Undefined:
  - Both addresses are unimplemented: read returns 0 and O_csr_addr_err=1.
  - No I_retire_WB port.

Decomposition:
- Package ysyx_040750_csr_pkg holds:
  - CSR address localparams (MSTATUS=12'h300, MTVEC, MEPC, MCAUSE, MCYCLE, MINSTRET).
  - mstatus bit-index constants (MIE=3, MPIE=7, MPP_LO=11, MPP_HI=12).
  - ECALL cause code.
- Optional sub-module ysyx_040750_csr_counter: one 64-bit counter with write-load priority over increment, instantiated twice under the macro.
- Read mux and trap logic stay in the top.

Test Plan:
- Reset: hold I_rst_n=0 for 2 cycles, release, read 0x300 -> 64'h0000_000a_0000_1800; 0x305/0x341/0x342 -> 0; O_csr_addr_err=0.
- Write then read: wen, addr=0x305, data=0x8000_0103 -> same cycle old value 0; next cycle O_csr_ID=0x8000_0100 and O_mtvec=0x8000_0100.
- ecall: mstatus MIE=1, I_ecall_WB=1, I_pc_WB=0x8000_0040 -> next cycle mepc=0x8000_0040, mcause=11, MIE=0, MPIE=1, MPP=3.
- mret after the ecall: I_mret_WB=1 -> MIE=1, MPIE=1; mepc still 0x8000_0040.
- Conflict: ecall with wen addr=0x341 data=0x1234, then separately ecall with wen addr=0x305 data=0x200 -> mepc=pc (write dropped); mtvec=0x200 (write kept).
- Illegal address: read 0x7C0 -> O_csr_ID=0, O_csr_addr_err=1. With the macro, mcycle reads 5 five cycles after reset release; write 0xFFFF_FFFF_FFFF_FFFF, read next cycle, then wraps to 0 the cycle after.

Source files
------------

// File: rtl/ysyx_040750_csr_pkg.sv
// Shared CSR addresses, mstatus field positions and the ecall cause code
// for the machine-mode CSR register file.
package ysyx_040750_csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET = 12'hB02;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_LO = 11;
   localparam int MSTATUS_MPP_HI = 12;

   localparam logic [63:0] CAUSE_ECALL_M = 64'd11;

endpackage

// File: rtl/ysyx_040750_csr_counter.sv
// Free-running CSR counter; a CSR write loads the value and suppresses
// that cycle's increment. Wraps naturally at 2^WIDTH.
module ysyx_040750_csr_counter
   import ysyx_040750_csr_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             I_clk,
   input  logic             I_rst_n,
   input  logic             I_inc,
   input  logic             I_wen,
   input  logic [WIDTH-1:0] I_wdata,
   output logic [WIDTH-1:0] O_count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   // next count: write load first, otherwise conditional increment
   always_comb begin
      count_d = count_q;
      if (I_wen) begin
         count_d = I_wdata;
      end else if (I_inc) begin
         count_d = count_q + WIDTH'(1);
      end
   end

   // counter register with synchronous active-low reset
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign O_count = count_q;

endmodule

// File: rtl/ysyx_040750_csr_regfile.sv
// Machine-mode CSR storage: committed WB writes, combinational ID read,
// atomic ecall/mret updates and redirect targets for fetch.
// Optional mcycle/minstret counters: define YSYX_040750_CSR_COUNTER_EN.
module ysyx_040750_csr_regfile
   import ysyx_040750_csr_pkg::*;
#(
   parameter int             XLEN        = 64,
   parameter logic [XLEN-1:0] MSTATUS_RST = 64'h0000_000a_0000_1800,
   parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11
) (
   input  logic            I_clk,
   input  logic            I_rst_n,
   input  logic [11:0]     I_csr_addr_ID,
   output logic [XLEN-1:0] O_csr_ID,
   output logic            O_csr_addr_err,
   input  logic            I_csr_wen_WB,
   input  logic [11:0]     I_csr_addr_WB,
   input  logic [XLEN-1:0] I_csr_WB,
   input  logic            I_ecall_WB,
   input  logic            I_mret_WB,
   input  logic [XLEN-1:0] I_pc_WB,
`ifdef YSYX_040750_CSR_COUNTER_EN
   input  logic            I_retire_WB,
`endif
   output logic [XLEN-1:0] O_mtvec,
   output logic [XLEN-1:0] O_mepc
);

   // mtvec/mepc are word aligned; low two bits never hold state
   localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mtvec_q,   mtvec_d;
   logic [XLEN-1:0] mepc_q,    mepc_d;
   logic [XLEN-1:0] mcause_q,  mcause_d;

`ifdef YSYX_040750_CSR_COUNTER_EN
   logic [XLEN-1:0] mcycle;
   logic [XLEN-1:0] minstret;
   logic            mcycle_wen;
   logic            minstret_wen;

   assign mcycle_wen   = I_csr_wen_WB && (I_csr_addr_WB == CSR_MCYCLE);
   assign minstret_wen = I_csr_wen_WB && (I_csr_addr_WB == CSR_MINSTRET);

   ysyx_040750_csr_counter #(.WIDTH(XLEN)) u_mcycle (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_inc   (1'b1),
      .I_wen   (mcycle_wen),
      .I_wdata (I_csr_WB),
      .O_count (mcycle)
   );

   ysyx_040750_csr_counter #(.WIDTH(XLEN)) u_minstret (
      .I_clk   (I_clk),
      .I_rst_n (I_rst_n),
      .I_inc   (I_retire_WB),
      .I_wen   (minstret_wen),
      .I_wdata (I_csr_WB),
      .O_count (minstret)
   );
`endif

   // next-state: CSR write first, then ecall/mret override the fields they own
   always_comb begin
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      mcause_d  = mcause_q;
      if (I_csr_wen_WB) begin
         case (I_csr_addr_WB)
            CSR_MSTATUS: mstatus_d = I_csr_WB;
            CSR_MTVEC:   mtvec_d   = I_csr_WB & ALIGN_MASK;
            CSR_MEPC:    mepc_d    = I_csr_WB & ALIGN_MASK;
            CSR_MCAUSE:  mcause_d  = I_csr_WB;
            default: ;
         endcase
      end
      // trap updates start from the committed mstatus, so a same-cycle write is dropped
      if (I_ecall_WB) begin
         mepc_d                                  = I_pc_WB & ALIGN_MASK;
         mcause_d                                = ECALL_CAUSE;
         mstatus_d                               = mstatus_q;
         mstatus_d[MSTATUS_MPIE]                 = mstatus_q[MSTATUS_MIE];
         mstatus_d[MSTATUS_MIE]                  = 1'b0;
         mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end else if (I_mret_WB) begin
         mstatus_d                               = mstatus_q;
         mstatus_d[MSTATUS_MIE]                  = mstatus_q[MSTATUS_MPIE];
         mstatus_d[MSTATUS_MPIE]                 = 1'b1;
         mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
   end

   // architectural CSR registers with synchronous active-low reset
   always_ff @(posedge I_clk) begin
      if (!I_rst_n) begin
         mstatus_q <= MSTATUS_RST;
         mtvec_q   <= '0;
         mepc_q    <= '0;
         mcause_q  <= '0;
      end else begin
         mstatus_q <= mstatus_d;
         mtvec_q   <= mtvec_d;
         mepc_q    <= mepc_d;
         mcause_q  <= mcause_d;
      end
   end

   // ID read mux; no WB bypass here, the forwarding unit handles that
   always_comb begin
      O_csr_ID       = '0;
      O_csr_addr_err = 1'b0;
      case (I_csr_addr_ID)
         CSR_MSTATUS:  O_csr_ID = mstatus_q;
         CSR_MTVEC:    O_csr_ID = mtvec_q;
         CSR_MEPC:     O_csr_ID = mepc_q;
         CSR_MCAUSE:   O_csr_ID = mcause_q;
`ifdef YSYX_040750_CSR_COUNTER_EN
         CSR_MCYCLE:   O_csr_ID = mcycle;
         CSR_MINSTRET: O_csr_ID = minstret;
`endif
         default:      O_csr_addr_err = 1'b1;
      endcase
   end

   assign O_mtvec = mtvec_q;
   assign O_mepc  = mepc_q;

endmodule

// File: tb/tb_ysyx_040750_csr_regfile.sv
// Self-checking bench for ysyx_040750_csr_regfile. An associative-array
// model keyed by CSR address is compared with the DUT every negedge;
// directed literal checks pin the model to hand-computed values.
module tb_ysyx_040750_csr_regfile;

   localparam logic [63:0] MST_RST = 64'h0000_000a_0000_1800;

   logic        clk;
   logic        rst_n;
   logic [11:0] raddr;
   logic [63:0] rdata;
   logic        rerr;
   logic        wen;
   logic [11:0] waddr;
   logic [63:0] wdata;
   logic        ecall;
   logic        mret;
   logic [63:0] pc;
   logic [63:0] mtvec;
   logic [63:0] mepc;
`ifdef YSYX_040750_CSR_COUNTER_EN
   logic        retire;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 0;

   ysyx_040750_csr_regfile dut (
`ifdef YSYX_040750_CSR_COUNTER_EN
      .I_retire_WB    (retire),
`endif
      .I_clk          (clk),
      .I_rst_n        (rst_n),
      .I_csr_addr_ID  (raddr),
      .O_csr_ID       (rdata),
      .O_csr_addr_err (rerr),
      .I_csr_wen_WB   (wen),
      .I_csr_addr_WB  (waddr),
      .I_csr_WB       (wdata),
      .I_ecall_WB     (ecall),
      .I_mret_WB      (mret),
      .I_pc_WB        (pc),
      .O_mtvec        (mtvec),
      .O_mepc         (mepc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endfunction

   // behavioural model: CSR contents by address, updated per clock edge
   logic [63:0] mreg [int];
   logic [63:0] nreg [int];
   logic [63:0] ms;

   always @(posedge clk) begin
      if (!rst_n) begin
         mreg.delete();
         mreg[32'h300] = MST_RST;
         mreg[32'h305] = 64'd0;
         mreg[32'h341] = 64'd0;
         mreg[32'h342] = 64'd0;
`ifdef YSYX_040750_CSR_COUNTER_EN
         mreg[32'hB00] = 64'd0;
         mreg[32'hB02] = 64'd0;
`endif
      end else if (mreg.num() != 0) begin
         nreg = mreg;
`ifdef YSYX_040750_CSR_COUNTER_EN
         nreg[32'hB00] = mreg[32'hB00] + 64'd1;
         if (retire) nreg[32'hB02] = mreg[32'hB02] + 64'd1;
`endif
         if (wen && mreg.exists(int'(waddr)))
            nreg[int'(waddr)] = (waddr == 12'h305 || waddr == 12'h341) ? (wdata & ~64'h3) : wdata;
         if (ecall) begin
            nreg[32'h341] = pc & ~64'h3;
            nreg[32'h342] = 64'd11;
            ms = mreg[32'h300];
            ms[7] = ms[3];
            ms[3] = 1'b0;
            ms[12:11] = 2'b11;
            nreg[32'h300] = ms;
         end else if (mret) begin
            ms = mreg[32'h300];
            ms[3] = ms[7];
            ms[7] = 1'b1;
            ms[12:11] = 2'b11;
            nreg[32'h300] = ms;
         end
         mreg = nreg;
      end
   end

   // per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         if (mreg.exists(int'(raddr))) begin
            check("model_rdata", rdata, mreg[int'(raddr)]);
            check("model_err", 64'(rerr), 64'd0);
         end else begin
            check("model_rdata", rdata, 64'd0);
            check("model_err", 64'(rerr), 64'd1);
         end
         check("model_mtvec", mtvec, mreg[32'h305]);
         check("model_mepc", mepc, mreg[32'h341]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wen = 1'b0; ecall = 1'b0; mret = 1'b0;
   endtask

   task automatic rd(string name, logic [11:0] a, logic [63:0] exp, logic exp_err);
      raddr = a;
      #1;
      check(name, rdata, exp);
      check({name, "_err"}, 64'(rerr), 64'(exp_err));
   endtask

   initial begin
      rst_n = 1'b0; raddr = 12'h300; wen = 1'b0; waddr = 12'h0; wdata = 64'd0;
      ecall = 1'b0; mret = 1'b0; pc = 64'd0;
`ifdef YSYX_040750_CSR_COUNTER_EN
      retire = 1'b0;
`endif
      tick();
      tick();
      rst_n = 1'b1;
      chk_en = 1'b1;

      // reset values
      rd("rst_mstatus", 12'h300, MST_RST, 1'b0);
      rd("rst_mtvec",   12'h305, 64'd0, 1'b0);
      rd("rst_mepc",    12'h341, 64'd0, 1'b0);
      rd("rst_mcause",  12'h342, 64'd0, 1'b0);

      // write mtvec: old value visible this cycle, aligned value next cycle
      wen = 1'b1; waddr = 12'h305; wdata = 64'h8000_0103;
      rd("wr_same_cycle", 12'h305, 64'd0, 1'b0);
      tick(); idle();
      rd("wr_next_cycle", 12'h305, 64'h8000_0100, 1'b0);
      check("wr_mtvec_port", mtvec, 64'h8000_0100);

      // set MIE, then ecall
      wen = 1'b1; waddr = 12'h300; wdata = MST_RST | 64'h8;
      tick(); idle();
      ecall = 1'b1; pc = 64'h8000_0040;
      tick(); idle();
      rd("ecall_mepc",    12'h341, 64'h8000_0040, 1'b0);
      rd("ecall_mcause",  12'h342, 64'd11, 1'b0);
      rd("ecall_mstatus", 12'h300, 64'h0000_000a_0000_1880, 1'b0);

      // mret restores MIE from MPIE
      mret = 1'b1;
      tick(); idle();
      rd("mret_mstatus", 12'h300, 64'h0000_000a_0000_1888, 1'b0);
      check("mret_mepc", mepc, 64'h8000_0040);

      // ecall with conflicting mepc write: trap wins
      ecall = 1'b1; pc = 64'h8000_0100; wen = 1'b1; waddr = 12'h341; wdata = 64'h1234;
      tick(); idle();
      check("conf_mepc", mepc, 64'h8000_0100);
      // ecall with an mtvec write: write kept
      ecall = 1'b1; pc = 64'h8000_0202; wen = 1'b1; waddr = 12'h305; wdata = 64'h200;
      tick(); idle();
      check("conf_mtvec", mtvec, 64'h200);
      check("conf_mepc_align", mepc, 64'h8000_0200);

      // ecall and mret together: ecall wins (MPIE takes MIE=0)
      ecall = 1'b1; mret = 1'b1; pc = 64'h8000_0300;
      tick(); idle();
      rd("both_mstatus", 12'h300, 64'h0000_000a_0000_1800, 1'b0);

      // mret with a same-cycle mstatus write: mret wins
      mret = 1'b1; wen = 1'b1; waddr = 12'h300; wdata = 64'h0;
      tick(); idle();
      rd("mret_wr_mstatus", 12'h300, 64'h0000_000a_0000_1880, 1'b0);

      // unimplemented addresses, and a discarded write
      rd("illegal_rd", 12'h7C0, 64'd0, 1'b1);
      wen = 1'b1; waddr = 12'h7C0; wdata = 64'hDEAD;
      tick(); idle();
      rd("illegal_rd2", 12'h7C0, 64'd0, 1'b1);
`ifndef YSYX_040750_CSR_COUNTER_EN
      rd("no_mcycle", 12'hB00, 64'd0, 1'b1);
      rd("no_minstret", 12'hB02, 64'd0, 1'b1);
`endif

      // short sweep of writes across the address set, checked by the model
      for (int i = 0; i < 24; i++) begin
         wen = 1'b1;
         case (i % 6)
            0: waddr = 12'h300;
            1: waddr = 12'h305;
            2: waddr = 12'h341;
            3: waddr = 12'h342;
            4: waddr = 12'hB00;
            default: waddr = 12'h123;
         endcase
         wdata = {$urandom, $urandom};
         raddr = waddr;
         ecall = (i % 7 == 3);
         mret  = (i % 5 == 2);
         pc    = {$urandom, $urandom};
         tick();
      end
      idle();
      tick();

`ifdef YSYX_040750_CSR_COUNTER_EN
      // counters: reset, count five cycles, write-load priority, wrap
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      raddr = 12'hB00;
      repeat (5) tick();
      rd("mcycle_5", 12'hB00, 64'd5, 1'b0);
      wen = 1'b1; waddr = 12'hB00; wdata = 64'hFFFF_FFFF_FFFF_FFFF;
      tick(); idle();
      rd("mcycle_load", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
      tick();
      rd("mcycle_wrap", 12'hB00, 64'd0, 1'b0);
      retire = 1'b1;
      repeat (3) tick();
      retire = 1'b0;
      rd("minstret_3", 12'hB02, 64'd3, 1'b0);
      retire = 1'b1; wen = 1'b1; waddr = 12'hB02; wdata = 64'd100;
      tick(); idle(); retire = 1'b0;
      rd("minstret_load", 12'hB02, 64'd100, 1'b0);
`endif

      tick();
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
